shift_seq32: RTL and testbench
==============================

SHIFT_SEQ32 -- requirements
Module: shift_seq32

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data path width; only 32 is required to be supported.
REQ-002 The module SHALL have parameter SHW, default 5, giving the shift-amount width (log2 WIDTH).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port start, input, 1 bit: request a new shift operation.
REQ-006 The module SHALL have port flush, input, 1 bit: synchronous abort of the operation in flight (pipeline flush).
REQ-007 The module SHALL have port op, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-008 The module SHALL have port B, input, 32 bits: operand to be shifted.
REQ-009 The module SHALL have port shamt, input, 5 bits: shift amount, 0..31.
REQ-010 The module SHALL have port busy, output, 1 bit: high while shifting; start is ignored while busy is high.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse; res is valid in that cycle.
REQ-012 The module SHALL have port res, output, 32 bits: shifted result, held until the next accepted start or reset.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 start SHALL be accepted in IDLE or DONE; the cycle of acceptance is cycle 0, and B, op and shamt are latched on that edge (data register <= B, count <= shamt).
REQ-015 On acceptance with shamt=0 the next state SHALL be DONE; with shamt>0 the next state SHALL be SHIFT.
REQ-016 Each SHIFT cycle SHALL shift the data register by exactly one bit per the latched op and decrement count; when count==1 the next state is DONE.
REQ-017 The shift-in bit SHALL be 0 for SLL and SRL, data[31] for SRA, and data[0] for ROR (inserted at bit 31).
REQ-018 Latency SHALL be fixed: done asserts in cycle shamt+1 (cycle 1 when shamt=0).
REQ-019 In DONE, done=1, busy=0, and res SHALL equal the final data register value.
REQ-020 From DONE, the FSM SHALL go to IDLE unless start=1, in which case the new operation is accepted (back-to-back, no bubble).
REQ-021 busy SHALL be 1 exactly when state==SHIFT.
REQ-022 res SHALL update only on entry to DONE; it SHALL NOT expose intermediate shift values.
REQ-023 start asserted while busy SHALL be ignored, with no latch and no effect on the current operation.
REQ-024 flush=1 SHALL force the next state to IDLE from any state: done is not pulsed for the aborted operation, res keeps its prior value, and start in the same cycle is ignored.
REQ-025 Priority SHALL be rst > flush > start.
REQ-026 The result SHALL be bit-exact with single-cycle reference operations B<<n, B>>n, $signed(B)>>>n and rotate-right of B by n.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, busy=0, done=0, res=0x00000000, data register=0 and count=0.
REQ-028 rst asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst is released is accepted normally.

Structure
REQ-029 The op encodings (SLL/SRL/SRA/ROR) and the FSM state encodings SHALL live in a shared package, shift_pkg, reused by the ALU control decode.
REQ-030 The one-bit shift/rotate step SHALL be a combinational sub-module shift1_32 (inputs data and op, output data shifted by one bit), instantiated once.
REQ-031 No multipliers or barrel shifters SHALL be used; the only datapath SHALL be one 32-bit register, one 5-bit counter and shift1_32.

Verification
REQ-032 The bench SHALL cover: SRL, B=0x80000000, shamt=31 -> done in cycle 32, res=0x00000001, busy high in cycles 1..31.
REQ-033 The bench SHALL cover: SRA, B=0x80000000, shamt=4 -> done in cycle 5, res=0xF8000000; SLL, B=0x12345678, shamt=0 -> done in cycle 1, res=0x12345678.
REQ-034 The bench SHALL cover: ROR, B=0x00000001, shamt=1, with a second start (SLL, shamt=3) pulsed in cycle 1 -> second start ignored, done in cycle 2, res=0x80000000.
REQ-035 The bench SHALL cover: back-to-back start held high in the DONE cycle (SLL, B=0x1, shamt=2 then shamt=3) -> done in cycles 3 and 7, res=0x4 then 0x8.
REQ-036 The bench SHALL cover: flush in cycle 3 of SRL, shamt=10, with prior res=0xDEADBEEF -> no done pulse, busy=0 from cycle 4, res stays 0xDEADBEEF; rst in cycle 3 instead -> no done pulse, res=0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: ALU shift opcodes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift1_32.sv
// One-bit shift/rotate step; the only datapath operator of the sequential shifter.
module shift1_32
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  shift_op_e        op,
  output logic [WIDTH-1:0] data_sh
);

  always_comb begin
    data_sh = data;
    case (op)
      OP_SLL:  data_sh = {data[WIDTH-2:0], 1'b0};
      OP_SRL:  data_sh = {1'b0, data[WIDTH-1:1]};
      OP_SRA:  data_sh = {data[WIDTH-1], data[WIDTH-1:1]};
      OP_ROR:  data_sh = {data[0], data[WIDTH-1:1]};
      default: data_sh = data;
    endcase
  end

endmodule

// File: rtl/shift_seq32.sv
// Multi-cycle shifter: one bit per cycle, fixed latency shamt+1, result held until next start.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_SHIFT | one bit shifted per cycle, count runs down to 1
//   ST_DONE  | done pulse, res valid; start here is accepted back-to-back
module shift_seq32
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  shift_state_e     state, state_nxt;
  logic [WIDTH-1:0] data, data_sh, res_nxt;
  logic [SHW-1:0]   count;
  shift_op_e        op_q;
  logic             load, step, res_load;

  shift1_32 #(.WIDTH(WIDTH)) u_shift1 (
    .data    (data),
    .op      (op_q),
    .data_sh (data_sh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      data  <= '0;
      count <= '0;
      op_q  <= OP_SLL;
      res   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        data  <= B;
        count <= shamt;
        op_q  <= shift_op_e'(op);
      end else if (step) begin
        data  <= data_sh;
        count <= count - SHW'(1);
      end
      if (res_load) res <= res_nxt;
    end
  end

  // res is loaded only on the edge into DONE so intermediate values never leak out
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    res_load  = 1'b0;
    res_nxt   = data_sh;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (!flush && start) begin
          load = 1'b1;
          if (shamt == '0) begin
            state_nxt = ST_DONE;
            res_load  = 1'b1;
            res_nxt   = B;
          end else begin
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else begin
          step = 1'b1;
          if (count == SHW'(1)) begin
            state_nxt = ST_DONE;
            res_load  = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_seq32.sv
// Scoreboard bench for shift_seq32: driver pushes expected (result, done cycle), monitor pops on done.
module tb_shift_seq32;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        busy, done;
  logic [31:0] res;

  shift_seq32 #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .flush (flush),
    .op    (op),
    .B     (B),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .res   (res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          busy_lo = 0;
  int          busy_hi = -1;
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  logic [31:0] held = '0;
  int          chk_seq = 0;
  int          chk_seen = 0;
  logic [31:0] chk_exp;
  string       chk_name;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference shift computed directly from the operation definitions.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] b, input int n);
    logic signed [31:0] sb;
    logic [63:0]        rr;
    case (o)
      2'b00:   return b << n;
      2'b01:   return b >> n;
      2'b10: begin
        sb = $signed(b) >>> n;
        return sb;
      end
      default: begin
        rr = {b, b} >> n;
        return rr[31:0];
      end
    endcase
  endfunction

  // Called just after a rising edge; drives one cycle of inputs and updates the model.
  task automatic drive(input bit s, input bit f, input bit r,
                       input logic [1:0] o, input logic [31:0] b, input int n);
    exp_t e;
    start = s; flush = f; rst = r; op = o; B = b; shamt = 5'(n);
    if (r || f) begin
      if (busy_hi > cyc) busy_hi = cyc;
    end else if (s && cyc > busy_hi) begin
      e.res = ref_shift(o, b, n);
      e.cyc = cyc + n + 1;
      q.push_back(e);
      busy_lo = cyc + 1;
      busy_hi = cyc + n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 0);
  endtask

  task automatic drain();
    int budget = 100;
    while ((q.size() > 0 || cyc <= busy_hi + 1) && budget > 0) begin
      idle(1);
      budget--;
    end
    idle(1);
  endtask

  task automatic check_res(input string name, input logic [31:0] e);
    chk_name = name;
    chk_exp  = e;
    chk_seq++;
    idle(1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missing_done: no done in cycle %0d, required res=%h", q[0].cyc, q[0].res);
        void'(q.pop_front());
      end
      checks++;
      if (busy !== (cyc >= busy_lo && cyc <= busy_hi)) begin
        errors++;
        $display("FAIL busy: cycle %0d got %b required %b", cyc, busy, (cyc >= busy_lo && cyc <= busy_hi));
      end
      if (done === 1'b1) begin
        checks++;
        if (q.size() == 0 || q[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_done: cycle %0d res=%h, required no done", cyc, res);
        end else begin
          if (res !== q[0].res) begin
            errors++;
            $display("FAIL done_res: cycle %0d got %h required %h", cyc, res, q[0].res);
          end
          held = q[0].res;
          void'(q.pop_front());
        end
      end else if (done !== 1'b0) begin
        checks++; errors++;
        $display("FAIL done_x: cycle %0d got %b required 0/1", cyc, done);
      end
      checks++;
      if (res !== held) begin
        errors++;
        $display("FAIL res_hold: cycle %0d got %h required %h", cyc, res, held);
      end
      if (chk_seq != chk_seen) begin
        checks++;
        if (res !== chk_exp) begin
          errors++;
          $display("FAIL %s: got %h required %h", chk_name, res, chk_exp);
        end
        chk_seen = chk_seq;
      end
      if (rst === 1'b1 || flush === 1'b1)
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
      if (rst === 1'b1) held = '0;
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; B = '0; shamt = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 0);
    check_res("reset_res", 32'h0);

    // SRL long shift
    drive(1'b1, 1'b0, 1'b0, 2'b01, 32'h8000_0000, 31);
    drain();
    check_res("srl31", 32'h0000_0001);

    // SRA sign fill, then zero-amount SLL
    drive(1'b1, 1'b0, 1'b0, 2'b10, 32'h8000_0000, 4);
    drain();
    check_res("sra4", 32'hF800_0000);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h1234_5678, 0);
    drain();
    check_res("sll0", 32'h1234_5678);

    // ROR with a start pulsed while busy
    drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0001, 1);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0001, 3);
    drain();
    check_res("ror1_ignore", 32'h8000_0000);

    // start held high through the DONE cycle
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h1, 2);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h1, 3);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h1, 3);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h1, 3);
    drain();
    check_res("b2b", 32'h0000_0008);

    // flush in cycle 3, with a start in the same cycle
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF, 0);
    drain();
    drive(1'b1, 1'b0, 1'b0, 2'b01, 32'hFFFF_0000, 10);
    idle(2);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 32'h5, 0);
    drain();
    check_res("flush_hold", 32'hDEAD_BEEF);

    // reset mid-operation, then a normal start
    drive(1'b1, 1'b0, 1'b0, 2'b01, 32'hFFFF_0000, 10);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 0);
    drain();
    check_res("rst_abort", 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_00F1, 4);
    drain();
    check_res("after_rst", 32'h1000_000F);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5);
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 79) == 0,
            2'($urandom_range(0, 3)), $urandom, n);
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
